// File: rtl/divider_seq_pkg.sv
// Shared constants for the sequential restoring divider.
// Latency: none (constants and elaboration-time helpers only).
// Backpressure: not applicable.
package divider_seq_pkg;

    // FSM encoding shared by the divider top and anything that decodes it.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Default operand width, chosen to pair with the 4-bit multiplier outputs.
    localparam int DIV_WIDTH_DEFAULT = 4;

    // Iteration counter width: must be able to hold the value WIDTH itself.
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W_DEFAULT = div_cnt_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/divider_seq_div_step.sv
// One restoring-division step: shift a bit into the remainder, trial-subtract the divisor.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module div_step
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // The shifted remainder can reach 2*divisor-1, so the trial value keeps
    // one extra bit; the compare is done at WIDTH+1 bits to avoid overflow.
    logic [WIDTH:0] trial;

    assign trial = {rem_in, bit_in};

    // Quotient bit is set whenever the divisor fits into the trial remainder.
    assign q_bit = (trial >= {1'b0, divisor});

    // After a successful subtract the result is below the divisor, so it
    // always fits in WIDTH bits and the low-order subtract is exact.
    assign rem_out = q_bit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Latency: WIDTH+1 cycles accept->done; 1 cycle for divide-by-zero (and for I1<I2 when DIV_EARLY_EXIT_EN).
// Backpressure: start is ignored while busy (no queueing); a new start is taken in IDLE or in the DONE cycle.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int             CNT_W     = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] dividend;   // shifts left, MSB feeds the remainder
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;        // partial remainder
    logic [WIDTH-1:0] quo;        // quotient bits collected so far
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    logic accept;
    logic zero_div;
    logic early_exit;
    logic last_iter;
    logic load_run;

    // A request is taken whenever the divider is not iterating, which
    // includes the DONE cycle so results can be chained back to back.
    assign accept   = start && (state != RUN);
    assign zero_div = (I2 == '0);

`ifdef DIV_EARLY_EXIT_EN
    // Dividend smaller than divisor: the answer is known without iterating.
    assign early_exit = !zero_div && (I1 < I2);
`else
    assign early_exit = 1'b0;
`endif

    assign load_run  = accept && !zero_div && !early_exit;
    assign last_iter = (state == RUN) && (cnt == LAST_ITER);
    assign busy      = (state == RUN);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem),
        .bit_in  (dividend[WIDTH-1]),
        .divisor (divisor),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Control FSM: IDLE/DONE take new work, RUN counts WIDTH iterations,
    // done is a single-cycle pulse coinciding with the DONE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (last_iter) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (accept && (zero_div || early_exit)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (accept) begin
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Iteration datapath: load operands on accept, then one restoring
    // step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
        end else if (load_run) begin
            dividend <= I1;
            divisor  <= I2;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
        end else if (state == RUN) begin
            dividend <= {dividend[WIDTH-2:0], 1'b0};
            rem      <= step_rem;
            quo      <= {quo[WIDTH-2:0], step_q};
            cnt      <= cnt + 1'b1;
        end
    end

    // Result registers: only written when a result is produced, so the
    // previous answer stays visible while the next division is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && zero_div) begin
            Q           <= '1;
            R           <= I1;
            div_by_zero <= 1'b1;
        end else if (accept && early_exit) begin
            Q           <= '0;
            R           <= I1;
            div_by_zero <= 1'b0;
        end else if (last_iter) begin
            Q           <= {quo[WIDTH-2:0], step_q};
            R           <= step_rem;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: behavioural model plus directed literal checks.
// Latency: model predicts done/busy timing from the operand values.
// Backpressure: model ignores start while a division is outstanding.
module tb_divider_seq;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_LT = 1;
`else
    localparam int LAT_LT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] I1, I2, Q, R;
    logic         busy, done, div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .I1          (I1),
        .I2          (I2),
        .Q           (Q),
        .R           (R),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int           m_left = 0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

    function automatic int exp_latency(input int a, input int b);
        if (b == 0) return 1;
`ifdef DIV_EARLY_EXIT_EN
        if (a < b) return 1;
`endif
        return W + 1;
    endfunction

    task automatic publish();
        m_done = 1'b1;
        m_q    = p_q;
        m_r    = p_r;
        m_dbz  = p_dbz;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_left = 0; m_busy = 1'b0; m_done = 1'b0;
            m_q = '0; m_r = '0; m_dbz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) publish();
            end else if (start === 1'b1) begin
                if (I2 == '0) begin
                    p_q = '1; p_r = I1; p_dbz = 1'b1;
                end else begin
                    p_q   = W'(int'(I1) / int'(I2));
                    p_r   = W'(int'(I1) % int'(I2));
                    p_dbz = 1'b0;
                end
                m_left = exp_latency(int'(I1), int'(I2)) - 1;
                if (m_left == 0) publish();
            end
            m_busy = (m_left > 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            #1;
            n_tests++;
            if ({busy, done, div_by_zero, Q, R} !== {m_busy, m_done, m_dbz, m_q, m_r}) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t dut busy=%b done=%b dbz=%b Q=%0d R=%0d model busy=%b done=%b dbz=%b Q=%0d R=%0d",
                         $time, busy, done, div_by_zero, Q, R, m_busy, m_done, m_dbz, m_q, m_r);
            end
            @(posedge clk);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input int a, input int b, output int lat, output int busy_cnt);
        I1 = W'(a); I2 = W'(b); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL timeout %0d/%0d: no done within %0d cycles", a, b, lat);
        end
    endtask

    task automatic chk_arith(input int a, input int b, input int lat);
        if (b == 0) begin
            chk("dz_Q", int'(Q), MAXV);
            chk("dz_R", int'(R), a);
            chk("dz_flag", int'(div_by_zero), 1);
        end else begin
            chk("identity", int'(Q) * b + int'(R), a);
            chk("rem_lt_div", int'(int'(R) < b), 1);
            chk("nz_flag", int'(div_by_zero), 0);
        end
        chk("latency", lat, exp_latency(a, b));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, bc, dcnt;
        rst_n = 1'b0; start = 1'b0; I1 = '0; I2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_Q", int'(Q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 13/3: normal full-latency division
        run_op(13, 3, lat, bc);
        chk("13/3_Q", int'(Q), 4);
        chk("13/3_R", int'(R), 1);
        chk("13/3_dbz", int'(div_by_zero), 0);
        chk("13/3_lat", lat, 5);
        chk("13/3_busy", bc, 4);
        repeat (2) @(negedge clk);

        // 9/0 then edge values, each started in the previous DONE cycle
        run_op(9, 0, lat, bc);
        chk("9/0_Q", int'(Q), 15);
        chk("9/0_R", int'(R), 9);
        chk("9/0_dbz", int'(div_by_zero), 1);
        chk("9/0_lat", lat, 1);
        run_op(15, 1, lat, bc);
        chk("15/1_Q", int'(Q), 15);
        chk("15/1_R", int'(R), 0);
        chk("15/1_lat", lat, 5);
        run_op(0, 7, lat, bc);
        chk("0/7_Q", int'(Q), 0);
        chk("0/7_R", int'(R), 0);
        chk("0/7_lat", lat, LAT_LT);
        run_op(7, 7, lat, bc);
        chk("7/7_Q", int'(Q), 1);
        chk("7/7_R", int'(R), 0);
        run_op(2, 9, lat, bc);
        chk("2/9_Q", int'(Q), 0);
        chk("2/9_R", int'(R), 2);
        chk("2/9_lat", lat, LAT_LT);
        repeat (2) @(negedge clk);

        // start during RUN must be ignored
        I1 = 4'd14; I2 = 4'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        I1 = 4'd6; I2 = 4'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        chk("14/4_done_seen", int'(done), 1);
        chk("14/4_Q", int'(Q), 3);
        chk("14/4_R", int'(R), 2);
        dcnt = 0;
        repeat (8) begin @(negedge clk); if (done === 1'b1) dcnt++; end
        chk("no_second_done", dcnt, 0);

        // reset in the middle of 13/3
        I1 = 4'd13; I2 = 4'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_Q", int'(Q), 0);
        chk("midrst_R", int'(R), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (8) begin @(negedge clk); if (done === 1'b1) dcnt++; end
        chk("midrst_no_done", dcnt, 0);
        chk("midrst_Q_stable", int'(Q), 0);

        // exhaustive operand sweep with random idle gaps
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                run_op(a, b, lat, bc);
                chk_arith(a, b, lat);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        // free-running random traffic, including starts while busy
        repeat (600) begin
            start = ($urandom_range(0, 2) == 0);
            I1    = W'($urandom);
            I2    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
